// File: rtl/pong_game_sequencer_pkg.sv
// Shared types and widths for the Pong game sequencer: FSM encoding, score/level
// widths and the ball step period helper.
package pong_game_sequencer_pkg;

  localparam int SCORE_W = 4;
  localparam int LEVEL_W = 2;
  localparam int FCNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_PAUSE    = 3'd3,
    ST_POINT    = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_e;

  // Frames between ball steps: the fastest level steps on every frame.
  function automatic logic [LEVEL_W:0] ball_period(input logic [LEVEL_W:0]   max_lvl,
                                                   input logic [LEVEL_W-1:0] lvl);
    return max_lvl + 1'b1 - {1'b0, lvl};
  endfunction

endpackage

// File: rtl/pong_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse the cycle after sig_i rises.
module pong_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q, rise_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
      rise_q <= sig_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/pong_game_sequencer.sv
// Pong game controller: serve/play/point/game-over flow, scores, speed level and
// frame-derived ball/paddle step enables. All outputs registered.
module pong_game_sequencer
  import pong_game_sequencer_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int MAX_LEVEL    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               speed_up,
  input  logic               speed_down,
  input  logic               point_left,
  input  logic               point_right,
  output logic               ball_step_en,
  output logic               paddle_step_en,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [LEVEL_W-1:0] speed_level,
  output logic [2:0]         game_state,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN_N   = SCORE_W'(WIN_SCORE);
  localparam logic [FCNT_W-1:0]  SERVE_N = FCNT_W'(SERVE_FRAMES);
  localparam logic [FCNT_W-1:0]  POINT_N = FCNT_W'(POINT_FRAMES);
  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W:0]   LVL_MX1 = (LEVEL_W+1)'(MAX_LEVEL);

  logic start_rise, pause_rise;

  pong_edge_detect u_start_ed (.clk(clk), .rst(rst), .sig_i(start_btn), .rise_o(start_rise));
  pong_edge_detect u_pause_ed (.clk(clk), .rst(rst), .sig_i(pause_btn), .rise_o(pause_rise));

  state_e             state_q, state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d, fcnt_inc;
  logic [LEVEL_W:0]   div_q, div_d, div_inc, period;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               serve_dir_q, serve_dir_d, winner_q, winner_d;
  logic               ball_rst_q, ball_rst_d, ball_en_q, ball_en_d, pad_en_q, pad_en_d;
  logic               lvl_chg;

  assign fcnt_inc = fcnt_q + 1'b1;
  assign div_inc  = div_q + 1'b1;
  assign period   = ball_period(LVL_MX1, level_q);

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    div_d       = div_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    level_d     = level_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    ball_en_d   = 1'b0;
    pad_en_d    = 1'b0;
    ball_rst_d  = 1'b1;
    lvl_chg     = 1'b0;

    if (speed_up && !speed_down && level_q != LVL_MAX) begin
      level_d = level_q + 1'b1;
      lvl_chg = 1'b1;
    end else if (speed_down && !speed_up && level_q != '0) begin
      level_d = level_q - 1'b1;
      lvl_chg = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_GAMEOVER: begin
        if (start_rise) begin
          state_d   = ST_SERVE;
          fcnt_d    = '0;
          score_l_d = '0;
          score_r_d = '0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          pad_en_d = 1'b1;
          fcnt_d   = fcnt_inc;
          if (fcnt_inc >= SERVE_N) begin
            state_d = ST_PLAY;
            fcnt_d  = '0;
            div_d   = '0;
          end
        end
      end
      ST_PLAY: begin
        // A single point takes priority over pause and over this frame's steps.
        if (point_left ^ point_right) begin
          fcnt_d = '0;
          if (point_left) begin
            score_l_d   = score_l_q + 1'b1;
            serve_dir_d = 1'b1;
            winner_d    = (score_l_d == WIN_N) ? 1'b0 : winner_q;
            state_d     = (score_l_d == WIN_N) ? ST_GAMEOVER : ST_POINT;
          end else begin
            score_r_d   = score_r_q + 1'b1;
            serve_dir_d = 1'b0;
            winner_d    = (score_r_d == WIN_N) ? 1'b1 : winner_q;
            state_d     = (score_r_d == WIN_N) ? ST_GAMEOVER : ST_POINT;
          end
        end else if (pause_rise) begin
          state_d = ST_PAUSE;
          fcnt_d  = '0;
        end else if (frame_tick) begin
          pad_en_d = 1'b1;
          if (div_inc >= period) begin
            ball_en_d = 1'b1;
            div_d     = '0;
          end else begin
            div_d = div_inc;
          end
        end
      end
      ST_PAUSE: begin
        if (pause_rise) begin
          state_d = ST_PLAY;
          fcnt_d  = '0;
        end
      end
      ST_POINT: begin
        if (frame_tick) begin
          fcnt_d = fcnt_inc;
          if (fcnt_inc >= POINT_N) begin
            state_d = ST_SERVE;
            fcnt_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        fcnt_d  = '0;
      end
    endcase

    if (lvl_chg) div_d = '0;

    // Ball leaves centre only while rallying; after a point it is released for one frame.
    case (state_d)
      ST_PLAY, ST_PAUSE: ball_rst_d = 1'b0;
      ST_POINT:          ball_rst_d = (fcnt_d != '0);
      default:           ball_rst_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fcnt_q      <= '0;
      div_q       <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      level_q     <= '0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      ball_rst_q  <= 1'b1;
      ball_en_q   <= 1'b0;
      pad_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      div_q       <= div_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      level_q     <= level_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      ball_rst_q  <= ball_rst_d;
      ball_en_q   <= ball_en_d;
      pad_en_q    <= pad_en_d;
    end
  end

  assign ball_step_en   = ball_en_q;
  assign paddle_step_en = pad_en_q;
  assign ball_reset     = ball_rst_q;
  assign serve_dir      = serve_dir_q;
  assign score_left     = score_l_q;
  assign score_right    = score_r_q;
  assign speed_level    = level_q;
  assign game_state     = state_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer: directed game flow plus random stimulus, all
// outputs compared every cycle against a frame-level game model.
module tb_pong_game_sequencer;

  localparam int WIN = 3, SF = 2, PF = 2, ML = 3;
  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                         S_PAUSE = 3'd3, S_POINT = 3'd4, S_OVER = 3'd5;

  logic clk = 1'b0;
  logic rst, frame_tick, start_btn, pause_btn, speed_up, speed_down, point_left, point_right;
  logic ball_step_en, paddle_step_en, ball_reset, serve_dir, winner;
  logic [3:0] score_left, score_right;
  logic [1:0] speed_level;
  logic [2:0] game_state;

  always #5 clk = ~clk;

  pong_game_sequencer #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .MAX_LEVEL(ML)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .pause_btn(pause_btn), .speed_up(speed_up), .speed_down(speed_down),
    .point_left(point_left), .point_right(point_right),
    .ball_step_en(ball_step_en), .paddle_step_en(paddle_step_en),
    .ball_reset(ball_reset), .serve_dir(serve_dir), .score_left(score_left),
    .score_right(score_right), .speed_level(speed_level),
    .game_state(game_state), .winner(winner)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Game model: frames remaining in timed phases, frames until next ball step.
  logic [2:0] m_st;
  logic [3:0] m_sl, m_sr;
  logic [1:0] m_lvl;
  logic       m_dir, m_win, m_bstep, m_pstep;
  logic       m_sprev, m_pprev, m_spend, m_ppend;
  int         m_left, m_until, m_pt;

  function automatic logic m_brst();
    if (m_st == S_PLAY || m_st == S_PAUSE) return 1'b0;
    if (m_st == S_POINT) return (m_pt > 0);
    return 1'b1;
  endfunction

  task automatic model_step();
    logic sp, pp;
    if (rst) begin
      m_st = S_IDLE; m_sl = 0; m_sr = 0; m_lvl = 0; m_dir = 0; m_win = 0;
      m_bstep = 0; m_pstep = 0; m_left = 0; m_until = ML + 1; m_pt = 0;
      m_sprev = 0; m_pprev = 0; m_spend = 0; m_ppend = 0;
      return;
    end
    sp = m_spend; pp = m_ppend;
    m_spend = start_btn && !m_sprev; m_sprev = start_btn;
    m_ppend = pause_btn && !m_pprev; m_pprev = pause_btn;
    m_bstep = 0; m_pstep = 0;
    case (m_st)
      S_IDLE, S_OVER: if (sp) begin m_st = S_SERVE; m_sl = 0; m_sr = 0; m_left = SF; end
      S_SERVE: if (frame_tick) begin
        m_pstep = 1; m_left--;
        if (m_left == 0) begin m_st = S_PLAY; m_until = ML + 1 - int'(m_lvl); end
      end
      S_PLAY: begin
        if (point_left != point_right) begin
          if (point_left) begin m_sl++; m_dir = 1; end
          else begin m_sr++; m_dir = 0; end
          if (m_sl == WIN || m_sr == WIN) begin m_st = S_OVER; m_win = point_right; end
          else begin m_st = S_POINT; m_pt = 0; m_left = PF; end
        end else if (pp) m_st = S_PAUSE;
        else if (frame_tick) begin
          m_pstep = 1; m_until--;
          if (m_until == 0) begin m_bstep = 1; m_until = ML + 1 - int'(m_lvl); end
        end
      end
      S_PAUSE: if (pp) m_st = S_PLAY;
      S_POINT: if (frame_tick) begin
        m_pt++; m_left--;
        if (m_left == 0) begin m_st = S_SERVE; m_left = SF; end
      end
      default: m_st = S_IDLE;
    endcase
    if (speed_up && !speed_down && m_lvl < ML) begin m_lvl++; m_until = ML + 1 - int'(m_lvl); end
    else if (speed_down && !speed_up && m_lvl > 0) begin m_lvl--; m_until = ML + 1 - int'(m_lvl); end
  endtask

  int   cnt = 0, n_ball = 0, n_pad = 0;
  logic start_lvl = 1'b0, pause_lvl = 1'b0;

  task automatic cyc(input logic rs, input logic pl, input logic pr, input logic su, input logic sd);
    @(negedge clk);
    rst = rs; frame_tick = (cnt % 10 == 0); start_btn = start_lvl; pause_btn = pause_lvl;
    point_left = pl; point_right = pr; speed_up = su; speed_down = sd;
    @(posedge clk);
    model_step();
    #1;
    chk("outs", {ball_step_en, paddle_step_en, ball_reset, serve_dir, score_left, score_right,
                 speed_level, game_state, winner},
                {m_bstep, m_pstep, m_brst(), m_dir, m_sl, m_sr, m_lvl, m_st, m_win});
    n_ball += int'(ball_step_en);
    n_pad  += int'(paddle_step_en);
    cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic spd(input logic up);
    while (cnt % 10 == 0) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, up, !up);
  endtask

  task automatic press_start();
    start_lvl = 1'b1; run(3); start_lvl = 1'b0; run(1);
  endtask

  task automatic wait_st(input logic [2:0] s, input string tag);
    for (int i = 0; i < 300 && m_st != s; i++) cyc(0, 0, 0, 0, 0);
    chk(tag, game_state, s);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 0; start_btn = 0; pause_btn = 0;
    speed_up = 0; speed_down = 0; point_left = 0; point_right = 0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    chk("rst_state", game_state, S_IDLE);
    chk("rst_brst", ball_reset, 1);
    chk("rst_scores", {score_left, score_right}, 0);
    run(5);

    start_lvl = 1'b1; run(3); start_lvl = 1'b0;
    chk("serve", game_state, S_SERVE);
    chk("serve_brst", ball_reset, 1);
    wait_st(S_PLAY, "to_play");
    chk("play_brst", ball_reset, 0);

    n_ball = 0; n_pad = 0; run(160);
    chk("ball_l0", n_ball, 4);
    chk("pad_l0", n_pad, 16);
    for (int i = 0; i < 3; i++) spd(1);
    n_ball = 0; run(80);
    chk("ball_l3", n_ball, 8);
    spd(1);
    chk("lvl_sat", speed_level, 3);

    for (int i = 0; i < 3; i++) spd(0);
    run(25);
    pause_lvl = 1'b1; run(3);
    chk("pause", game_state, S_PAUSE);
    n_ball = 0; n_pad = 0; run(50);
    chk("pause_en", n_ball + n_pad, 0);
    pause_lvl = 1'b0; run(2); pause_lvl = 1'b1; run(3); pause_lvl = 1'b0;
    chk("resume", game_state, S_PLAY);
    run(60);

    cyc(0, 1, 1, 0, 0); run(2);
    chk("both_pts", {score_left, score_right}, 0);
    chk("both_st", game_state, S_PLAY);

    for (int i = 1; i <= 3; i++) begin
      wait_st(S_PLAY, "pl_play");
      if (i == 1) while (cnt % 10 != 0) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0); run(2);
      chk("score_l", score_left, i);
    end
    chk("over", game_state, S_OVER);
    chk("winner", winner, 0);
    n_ball = 0; n_pad = 0; run(40);
    chk("over_en", n_ball + n_pad, 0);

    press_start();
    chk("restart", {score_left, score_right}, 0);
    spd(1); spd(1);
    wait_st(S_PLAY, "p1"); cyc(0, 1, 0, 0, 0);
    wait_st(S_PLAY, "p2"); cyc(0, 0, 1, 0, 0);
    wait_st(S_PLAY, "p3"); cyc(0, 1, 0, 0, 0);
    chk("pt_21", {score_left, score_right}, 8'h21);
    chk("pt_state", game_state, S_POINT);
    cyc(1, 0, 0, 0, 0);
    chk("mid_rst", {game_state, score_left, score_right, speed_level}, 0);
    run(5);

    for (int i = 0; i < 15000 && errors < 40; i++) begin
      logic rs, pl, pr, su, sd, tk;
      if ($urandom_range(59) == 0) start_lvl = ~start_lvl;
      if ($urandom_range(79) == 0) pause_lvl = ~pause_lvl;
      pl = ($urandom_range(149) == 0);
      pr = ($urandom_range(149) == 0);
      tk = (cnt % 10 == 0);
      su = !tk && ($urandom_range(39) == 0);
      sd = !tk && ($urandom_range(39) == 0);
      rs = ($urandom_range(2999) == 0);
      cyc(rs, pl, pr, su, sd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
